// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: width defaults and state encoding.
// The optional imem timeout is enabled with the FETCH_TIMEOUT_EN macro.
package fetch_seq_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] HOLD  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] IDLE  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH = FETCH,
        S_WAIT  = WAIT,
        S_HOLD  = HOLD,
        S_DRAIN = DRAIN,
        S_IDLE  = IDLE
    } state_t;

endpackage

// File: rtl/fetch_seq_timer.sv
// Down-counting imem acknowledge watchdog; expired pulses on the TIMEOUT-th enabled cycle.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            remaining <= LOAD;
        end else if (enable && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expired = enable && (remaining == '0);

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer between pc, imem and decode; optional ack watchdog under FETCH_TIMEOUT_EN.
//
// state | meaning
// FETCH | sample pc_in and issue an imem request (waits while a PC write is landing)
// WAIT  | request outstanding, waiting for imem_ack
// HOLD  | instruction offered to decode until accepted
// DRAIN | redirected while a request was outstanding; swallow the ack
// IDLE  | halted (or locked out after a timeout)
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] next_pc,
    output logic              pc_write_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic              fetch_err
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    state_t state;

`ifdef FETCH_TIMEOUT_EN
    logic ack_pending;
    logic tmr_expired;

    assign ack_pending = (state == S_WAIT) || (state == S_DRAIN);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!ack_pending || imem_ack),
        .enable  (ack_pending && !imem_ack),
        .expired (tmr_expired)
    );
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            next_pc     <= '0;
            pc_write_en <= 1'b0;
            imem_addr   <= '0;
            imem_req    <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_err   <= 1'b0;
`endif
        end else begin
            pc_write_en <= 1'b0;

            if (br_taken) begin
                next_pc     <= br_target;
                pc_write_en <= 1'b1;
                instr_valid <= 1'b0;
                case (state)
                    S_WAIT, S_DRAIN: begin
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= S_FETCH;
                        end else begin
                            state    <= S_DRAIN;
                        end
                    end
                    default: state <= halt ? S_IDLE : S_FETCH;
                endcase
            end else begin
                case (state)
                    S_FETCH: begin
                        // While pc_write_en is high the PC register has not loaded yet.
                        if (halt) begin
                            state <= S_IDLE;
                        end else if (!pc_write_en) begin
                            imem_addr <= pc_in;
                            imem_req  <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_ack) begin
                            imem_req    <= 1'b0;
                            instr_out   <= imem_data;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            next_pc     <= instr_pc + PC_STEP;
                            pc_write_en <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_ack) begin
                            imem_req <= 1'b0;
                            state    <= S_FETCH;
                        end
                    end
                    S_IDLE: begin
                        if (!halt) begin
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end

`ifdef FETCH_TIMEOUT_EN
            // A timeout locks the block in IDLE until reset.
            if (tmr_expired) begin
                fetch_err   <= 1'b1;
                imem_req    <= 1'b0;
                instr_valid <= 1'b0;
                state       <= S_IDLE;
            end else if (fetch_err) begin
                state       <= S_IDLE;
            end
`endif
        end
    end

endmodule
